// File: rtl/atm_session_ctrl.sv
// -----------------------------------------------------------------------------
// atm_session_ctrl
//   Session sequencer for the ATM. It walks a card session through
//   IDLE -> PIN -> MENU <-> TXN -> EJECT/RETAIN. It also owns the shared
//   inactivity timer and drives its enable, restart, clear and threshold inputs.
//
// Ports
//   clk, rst         system clock; synchronous active-high reset
//   card_in          level, card present in the reader
//   key_press        pulse, any keypad key (restarts the inactivity timer)
//   pin_valid/pin_ok PIN entry complete / PIN matched
//   op_valid         pulse, menu operation selected
//   txn_done         pulse, datapath finished the transaction
//   cancel           pulse, cancel key
//   tmr_time_out     sticky timer expiry flag
//   tmr_start        timer enable (timed states only)
//   tmr_restart      one-cycle timer count restart
//   tmr_clr_n        active-low timer clear, low in entry cycles, IDLE, RETAIN
//   tmr_threshold    timer threshold for the current state
//   state_o          current state encoding
//   attempts_left    remaining PIN tries
//   session_ok       high in MENU and TXN
//   eject            level, high in EJECT
//   retain           one-cycle pulse, card swallowed
//   abort            one-cycle pulse, card pulled mid-session
// -----------------------------------------------------------------------------
module atm_session_ctrl #(
  parameter logic [31:0] PIN_TIMEOUT   = 32'd3000,
  parameter logic [31:0] MENU_TIMEOUT  = 32'd5000,
  parameter logic [31:0] TXN_TIMEOUT   = 32'd8000,
  parameter logic [31:0] EJECT_TIMEOUT = 32'd2000,
  parameter logic [1:0]  MAX_TRIES     = 2'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        card_in,
  input  logic        key_press,
  input  logic        pin_valid,
  input  logic        pin_ok,
  input  logic        op_valid,
  input  logic        txn_done,
  input  logic        cancel,
  input  logic        tmr_time_out,
  output logic        tmr_start,
  output logic        tmr_restart,
  output logic        tmr_clr_n,
  output logic [31:0] tmr_threshold,
  output logic [2:0]  state_o,
  output logic [1:0]  attempts_left,
  output logic        session_ok,
  output logic        eject,
  output logic        retain,
  output logic        abort
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PIN    = 3'd1,
    S_MENU   = 3'd2,
    S_TXN    = 3'd3,
    S_EJECT  = 3'd4,
    S_RETAIN = 3'd5
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  attempts_reg, attempts_next;
  // Cleared when a card is swallowed. IDLE only accepts a new card after
  // card_in has been seen low, so a stuck card-present level cannot restart a
  // session.
  logic        armed_reg, armed_next;
  logic        restart_reg, restart_next;
  logic        abort_reg, abort_next;
  logic        start_reg, clr_n_reg, sok_reg, eject_reg, retain_reg;
  logic [31:0] threshold_reg, threshold_next;
  logic        reenter;
  logic        entering;
  logic        timed_next;
  logic        entry;
  logic        timeout;

  // In a timed state the clear is low only in its first cycle. The registered
  // clear therefore doubles as the entry-cycle flag. The timer's sticky flag
  // may still be set from the previous state during that cycle, so it is
  // ignored then.
  assign entry   = ~clr_n_reg;
  assign timeout = tmr_time_out & ~entry;

  always_comb begin
    state_next    = state_reg;
    attempts_next = attempts_reg;
    armed_next    = armed_reg;
    restart_next  = 1'b0;
    abort_next    = 1'b0;
    reenter       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (!card_in) begin
          armed_next = 1'b1;
        end else if (armed_reg) begin
          state_next    = S_PIN;
          attempts_next = MAX_TRIES;
        end
      end
      S_PIN: begin
        if (!card_in) begin
          abort_next = 1'b1;
          state_next = S_IDLE;
        end else if (timeout || cancel) begin
          state_next = S_EJECT;
        end else if (pin_valid) begin
          if (pin_ok) begin
            state_next = S_MENU;
          end else begin
            attempts_next = attempts_reg - 2'd1;
            if (attempts_reg <= 2'd1) begin
              state_next = S_RETAIN;
              armed_next = 1'b0;
            end else begin
              reenter = 1'b1;
            end
          end
        end else if (key_press && !entry) begin
          restart_next = 1'b1;
        end
      end
      S_MENU: begin
        if (!card_in) begin
          abort_next = 1'b1;
          state_next = S_IDLE;
        end else if (timeout || cancel) begin
          state_next = S_EJECT;
        end else if (op_valid) begin
          state_next = S_TXN;
        end else if (key_press && !entry) begin
          restart_next = 1'b1;
        end
      end
      S_TXN: begin
        if (!card_in) begin
          abort_next = 1'b1;
          state_next = S_IDLE;
        end else if (timeout) begin
          state_next = S_EJECT;
        end else if (txn_done) begin
          state_next = S_MENU;
        end
      end
      S_EJECT: begin
        if (!card_in) begin
          state_next = S_IDLE;
        end else if (timeout) begin
          state_next = S_RETAIN;
          armed_next = 1'b0;
        end
      end
      S_RETAIN: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase

    entering   = (state_next != state_reg) || reenter;
    timed_next = (state_next == S_PIN) || (state_next == S_MENU) ||
                 (state_next == S_TXN) || (state_next == S_EJECT);

    case (state_next)
      S_PIN:   threshold_next = PIN_TIMEOUT;
      S_MENU:  threshold_next = MENU_TIMEOUT;
      S_TXN:   threshold_next = TXN_TIMEOUT;
      S_EJECT: threshold_next = EJECT_TIMEOUT;
      default: threshold_next = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      attempts_reg  <= MAX_TRIES;
      armed_reg     <= 1'b1;
      restart_reg   <= 1'b0;
      abort_reg     <= 1'b0;
      start_reg     <= 1'b0;
      clr_n_reg     <= 1'b0;
      threshold_reg <= 32'd0;
      sok_reg       <= 1'b0;
      eject_reg     <= 1'b0;
      retain_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      attempts_reg  <= attempts_next;
      armed_reg     <= armed_next;
      restart_reg   <= restart_next;
      abort_reg     <= abort_next;
      start_reg     <= timed_next;
      clr_n_reg     <= timed_next & ~entering;
      threshold_reg <= threshold_next;
      sok_reg       <= (state_next == S_MENU) || (state_next == S_TXN);
      eject_reg     <= (state_next == S_EJECT);
      retain_reg    <= (state_next == S_RETAIN);
    end
  end

  assign state_o       = state_reg;
  assign attempts_left = attempts_reg;
  assign tmr_start     = start_reg;
  assign tmr_restart   = restart_reg;
  assign tmr_clr_n     = clr_n_reg;
  assign tmr_threshold = threshold_reg;
  assign session_ok    = sok_reg;
  assign eject         = eject_reg;
  assign retain        = retain_reg;
  assign abort         = abort_reg;

endmodule

// File: doc/atm_session_ctrl.md
Name: atm_session_ctrl

Overview:
- Top-level session sequencer for the ATM: card insert, PIN entry with retry limit, menu, transaction, card eject/retain.
- Owns and configures the shared inactivity timer: drives its start, restart, clear and threshold inputs, and consumes its time_out flag.
- Sits between keypad/card-reader front end and the transaction datapath.

Parameters:
- PIN_TIMEOUT, 32'd3000, timer threshold while in PIN state
- MENU_TIMEOUT, 32'd5000, threshold while in MENU
- TXN_TIMEOUT, 32'd8000, threshold while in TXN
- EJECT_TIMEOUT, 32'd2000, threshold for card collection before retain
- MAX_TRIES, 2'd3, wrong-PIN attempts allowed (1..3)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- card_in  in  1  level, card present in reader
- key_press  in  1  pulse, any keypad key
- pin_valid  in  1  pulse, PIN entry complete; qualifies pin_ok
- pin_ok  in  1  PIN matched (valid only with pin_valid)
- op_valid  in  1  pulse, menu operation selected
- txn_done  in  1  pulse, datapath finished transaction
- cancel  in  1  pulse, cancel key
- tmr_time_out  in  1  timer expiry flag; sticky until timer clear
- tmr_start  out  1  timer enable
- tmr_restart  out  1  timer count restart pulse
- tmr_clr_n  out  1  active-low timer clear, drives timer reset pin
- tmr_threshold  out  32  timer threshold for current state
- state_o  out  3  current state encoding
- attempts_left  out  2  remaining PIN tries
- session_ok  out  1  high in MENU and TXN
- eject  out  1  level, eject card
- retain  out  1  one-cycle pulse, card swallowed
- abort  out  1  one-cycle pulse, card removed mid-session

Behaviour:
- Encoding: IDLE=0, PIN=1, MENU=2, TXN=3, EJECT=4, RETAIN=5; others -> IDLE next cycle.
- All outputs registered. On rst (sync, high): state IDLE, tmr_start=0, tmr_restart=0, tmr_clr_n=0, tmr_threshold=0, attempts_left=MAX_TRIES, session_ok=0, eject=0, retain=0, abort=0.
- Timed states PIN, MENU, TXN, EJECT: tmr_start=1; tmr_threshold=matching parameter.
- Entry cycle: first cycle in any timed state, including PIN re-entry after wrong PIN, has tmr_clr_n=0 and tmr_time_out ignored.
- tmr_clr_n is 0 in IDLE and RETAIN; tmr_start is 0 in IDLE and RETAIN.
- Event priority per cycle: card removal > timeout > cancel > pin_valid/op_valid/txn_done > key_press.
- Timeout: tmr_time_out=1, not in entry cycle.
- IDLE: card_in=1 -> PIN; attempts_left=MAX_TRIES.
- PIN:
  - key_press -> tmr_restart=1 for one cycle.
  - pin_valid & pin_ok -> MENU.
  - pin_valid & !pin_ok: attempts_left decrements; if it reaches 0 -> RETAIN, else re-enter PIN (timer cleared).
  - timeout or cancel -> EJECT.
- MENU:
  - key_press -> restart pulse.
  - op_valid -> TXN.
  - timeout or cancel -> EJECT.
- TXN:
  - txn_done -> MENU.
  - timeout -> EJECT.
  - cancel and key_press ignored.
- EJECT:
  - eject=1.
  - card_in=0 -> IDLE.
  - timeout -> RETAIN.
- RETAIN: retain=1 for its single cycle; eject=0; -> IDLE next cycle. IDLE is not left while card_in stays high after retain until card_in has been seen low for one cycle.
- Card removal: card_in=0 in PIN, MENU or TXN -> abort=1 for one cycle, -> IDLE.
- tmr_restart: never asserted in entry cycles or in a cycle that changes state.
- attempts_left: holds except on wrong PIN; reloads on IDLE->PIN.

Test Plan:
- Happy path. Bench params: all timeouts=20, MAX_TRIES=3. Stimulus: card_in=1, pin_valid+pin_ok, op_valid, txn_done, cancel, card_in=0. Required state sequence: 0->1->2->3->2->4->0; session_ok=1 only in states 2/3; eject=1 in state 4.
- Wrong PIN ×3 -> attempts_left 3->2->1->0; tmr_clr_n low one cycle per re-entry; RETAIN with retain pulse; then IDLE held until card_in low.
- PIN timeout: no keys for 20+ cycles -> EJECT, tmr_threshold switches 20(PIN)->20(EJECT) with clr pulse. key_press every 10 cycles instead -> tmr_restart pulses, no exit for 100 cycles.
- Card not collected in EJECT -> tmr_time_out -> retain pulse, state 5 then 0.
- Simultaneous events in PIN:
  - tmr_time_out + pin_valid&pin_ok same cycle -> EJECT, not MENU.
  - card_in=0 + cancel -> abort pulse, IDLE.
- rst asserted mid-TXN -> next cycle all outputs at reset values; state 0; tmr_clr_n=0.
